// File: rtl/cam_pkg.sv
// Shared definitions for the multi-image pixel CAM.
//   - cam_state_e : search FSM encodings (IDLE/SCAN/DRAIN/DONE)
//   - cam_clog2   : address-width helper (never returns less than 1)
//   - default parameter values for cam_image_search
package cam_pkg;

  localparam int CAM_N_IMG_DEF = 2;
  localparam int CAM_DEPTH_DEF = 16384;
  localparam int CAM_DW_DEF    = 24;

  typedef enum logic [1:0] {
    CAM_IDLE  = 2'd0,
    CAM_SCAN  = 2'd1,
    CAM_DRAIN = 2'd2,
    CAM_DONE  = 2'd3
  } cam_state_e;

  function automatic int cam_clog2(input int value);
    int res;
    res = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) res = i + 1;
    end
    return (res < 1) ? 1 : res;
  endfunction

endpackage

// File: rtl/cam_image_bank.sv
// One image bank of the CAM: pixel RAM, per-entry valid bits and a
// registered comparator.
// Ports:
//   clk, reset   clock, asynchronous active-low reset
//   we           write strobe (already qualified by the top: idle and in range)
//   waddr, wdata write address / pixel
//   clear        synchronous invalidate of every entry
//   raddr        scan address (RAM read latency 1)
//   key, mask    search key and don't-care mask (mask bit 1 = ignore)
//   hit          registered compare result for the address issued two cycles earlier
module cam_image_bank
  import cam_pkg::*;
#(
  parameter int DW    = CAM_DW_DEF,
  parameter int DEPTH = CAM_DEPTH_DEF,
  localparam int AW   = cam_clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          clear,
  input  logic [AW-1:0] raddr,
  input  logic [DW-1:0] key,
  input  logic [DW-1:0] mask,
  output logic          hit
);

  logic [DW-1:0]    mem [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DW-1:0]    rdata_q, rdata_d;
  logic             vld_rd_q, vld_rd_d;
  logic             hit_q, hit_d;

  always_comb begin
    valid_d = valid_q;
    if (we) valid_d[waddr] = 1'b1;
    // Invalidate wins over a simultaneous write.
    if (clear) valid_d = '0;
    rdata_d  = mem[raddr];
    vld_rd_d = valid_q[raddr];
    // An invalid entry never hits, whatever stale data the RAM holds.
    hit_d    = vld_rd_q & (((rdata_q ^ key) & ~mask) == '0);
  end

  // RAM array has no reset; only the valid bits qualify its contents.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata_q <= rdata_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q  <= '0;
      vld_rd_q <= 1'b0;
      hit_q    <= 1'b0;
    end else begin
      valid_q  <= valid_d;
      vld_rd_q <= vld_rd_d;
      hit_q    <= hit_d;
    end
  end

  assign hit = hit_q;

endmodule

// File: rtl/cam_image_search.sv
// Multi-image content-addressable pixel store. N_IMG banks are written
// independently and searched in parallel, one address per cycle; the top
// reports per-image hit flags and the lowest hitting address.
// Ports:
//   clk, reset        clock, asynchronous active-low reset
//   we[N_IMG]         per-image write enable (ignored while busy)
//   addr, din         write address / pixel; din is also the search key
//   search_req        start a search (accepted when idle and clear low)
//   clear             invalidate all entries, abort any running search
//   search_mask       (only with CAM_MASK_EN) don't-care bits of the key
//   busy, done        search running / one-cycle completion pulse
//   match, match_addr per-image hit flags / lowest hitting address
// Optional feature macro: CAM_MASK_EN adds the search_mask port.
// Timing: accepting edge E0; address k is issued in the cycle after E(k),
// read at E(k+1), compared at E(k+2), accumulated at E(k+3). The last
// address therefore lands at E(DEPTH+2), the same edge done rises.
module cam_image_search
  import cam_pkg::*;
#(
  parameter int N_IMG = CAM_N_IMG_DEF,
  parameter int DEPTH = CAM_DEPTH_DEF,
  parameter int DW    = CAM_DW_DEF,
  localparam int AW   = cam_clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_IMG-1:0] we,
  input  logic [AW-1:0]    addr,
  input  logic [DW-1:0]    din,
  input  logic             search_req,
  input  logic             clear,
`ifdef CAM_MASK_EN
  input  logic [DW-1:0]    search_mask,
`endif
  output logic             busy,
  output logic             done,
  output logic [N_IMG-1:0] match,
  output logic [AW-1:0]    match_addr
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam int unsigned   DEPTH_U   = DEPTH;

  cam_state_e       state_q, state_d;
  logic [AW-1:0]    cnt_q, cnt_d;
  logic [DW-1:0]    key_q, key_d;
  logic [DW-1:0]    scan_mask;
  logic             s1_v_q, s1_v_d, s2_v_q, s2_v_d;
  logic [AW-1:0]    s1_addr_q, s1_addr_d, s2_addr_q, s2_addr_d;
  logic [N_IMG-1:0] match_q, match_d;
  logic [AW-1:0]    match_addr_q, match_addr_d;
  logic             done_q, done_d;
  logic [N_IMG-1:0] hit;
  logic             idle, accept, addr_ok;

  assign idle    = (state_q == CAM_IDLE);
  assign accept  = idle & search_req & ~clear;
  assign addr_ok = (32'(addr) < DEPTH_U);

`ifdef CAM_MASK_EN
  logic [DW-1:0] mask_q, mask_d;
  always_comb begin
    mask_d = mask_q;
    if (accept) mask_d = search_mask;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) mask_q <= '0;
    else        mask_q <= mask_d;
  end
  assign scan_mask = mask_q;
`else
  assign scan_mask = '0;
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    key_d        = key_q;
    // Two-stage tag pipeline that follows the banks' read + compare stages.
    s1_v_d       = (state_q == CAM_SCAN);
    s1_addr_d    = cnt_q;
    s2_v_d       = s1_v_q;
    s2_addr_d    = s1_addr_q;
    match_d      = match_q;
    match_addr_d = match_addr_q;
    done_d       = 1'b0;

    case (state_q)
      CAM_IDLE: begin
        if (accept) begin
          state_d      = CAM_SCAN;
          cnt_d        = '0;
          key_d        = din;
          match_d      = '0;
          match_addr_d = '0;
        end
      end
      CAM_SCAN: begin
        if (cnt_q == LAST_ADDR) state_d = CAM_DRAIN;
        else                    cnt_d   = cnt_q + 1'b1;
      end
      CAM_DRAIN: state_d = CAM_DONE;
      CAM_DONE: begin
        state_d = CAM_IDLE;
        done_d  = 1'b1;
      end
      default: state_d = CAM_IDLE;
    endcase

    // Addresses arrive in ascending order, so the first hit seen is the lowest.
    if (s2_v_q && (hit != '0)) begin
      match_d = match_q | hit;
      if (match_q == '0) match_addr_d = s2_addr_q;
    end

    if (clear) begin
      state_d      = CAM_IDLE;
      s1_v_d       = 1'b0;
      s2_v_d       = 1'b0;
      match_d      = '0;
      match_addr_d = '0;
      done_d       = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= CAM_IDLE;
      cnt_q        <= '0;
      key_q        <= '0;
      s1_v_q       <= 1'b0;
      s2_v_q       <= 1'b0;
      s1_addr_q    <= '0;
      s2_addr_q    <= '0;
      match_q      <= '0;
      match_addr_q <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      key_q        <= key_d;
      s1_v_q       <= s1_v_d;
      s2_v_q       <= s2_v_d;
      s1_addr_q    <= s1_addr_d;
      s2_addr_q    <= s2_addr_d;
      match_q      <= match_d;
      match_addr_q <= match_addr_d;
      done_q       <= done_d;
    end
  end

  for (genvar g = 0; g < N_IMG; g++) begin : g_bank
    cam_image_bank #(
      .DW    (DW),
      .DEPTH (DEPTH)
    ) u_bank (
      .clk   (clk),
      .reset (reset),
      .we    (we[g] & idle & addr_ok),
      .waddr (addr),
      .wdata (din),
      .clear (clear),
      .raddr (cnt_q),
      .key   (key_q),
      .mask  (scan_mask),
      .hit   (hit[g])
    );
  end

  assign busy       = ~idle;
  assign done       = done_q;
  assign match      = match_q;
  assign match_addr = match_addr_q;

endmodule
